cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL provide parameter FRAME_SKIP, default 10: the number of complete frames discarded after reset before output is enabled.
REQ-002 SHALL provide parameter H_PIX, default 1024: the expected 16-bit pixels per line, used for line-length checking.
REQ-003 SHALL provide parameter V_LINES, default 768: the expected lines per frame, used for frame-height checking.
REQ-004 SHALL have port sys_clk, input, 1: clock; the sensor pixel clock domain; all logic rises on it.
REQ-005 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port cam_vsync, input, 1: sensor frame sync, active-high pulse before each frame.
REQ-007 SHALL have port cam_href, input, 1: sensor line valid, active-high.
REQ-008 SHALL have port cam_din, input, 8: sensor byte; a pixel is high byte then low byte (RGB565).
REQ-009 SHALL have port pre_wr_en, output, 1: one-cycle strobe marking a valid packed pixel.
REQ-010 SHALL have port pre_vs, output, 1: vsync aligned to the pixel path.
REQ-011 SHALL have port pre_hs, output, 1: href aligned to the pixel path.
REQ-012 SHALL have port cam_data, output, 16: packed pixel {high, low}.
REQ-013 SHALL have port frame_valid, output, 1: output-enabled status, sticky.
REQ-014 SHALL have port err_line, output, 1: sticky line-length mismatch in the current frame.
REQ-015 SHALL have port err_frame, output, 1: one-cycle pulse on frame-height mismatch.

Function
REQ-016 SHALL register cam_vsync, cam_href and cam_din once (stage S1); all logic below uses only the S1 values.
REQ-017 SHALL detect a vsync rising edge (vs_rise) as S1 vsync=1 with the previous S1 vsync=0, and an href falling edge (hs_fall) likewise.
REQ-018 SHALL keep frame_cnt (saturating, ceil(log2(FRAME_SKIP+1)) bits): each vs_rise while frame_cnt<FRAME_SKIP increments it; the first vs_rise with frame_cnt==FRAME_SKIP sets frame_valid=1 on the following cycle.
REQ-019 SHALL, as a consequence of REQ-018, skip any partial first frame plus exactly FRAME_SKIP full frames; FRAME_SKIP=0 enables output at the first vs_rise.
REQ-020 SHALL keep frame_valid at 1 until reset once set.
REQ-021 SHALL toggle byte phase bf on every cycle S1 href=1, and force bf=0 whenever S1 href=0.
REQ-022 SHALL capture S1 cam_din into the high-byte register when bf=0.
REQ-023 SHALL, when bf=1, register cam_data={high, S1 cam_din} and assert pre_wr_en for one cycle only if frame_valid=1.
REQ-024 SHALL give a latency of 2 sys_clk edges from the low byte at the pins to pre_wr_en/cam_data.
REQ-025 SHALL discard an odd trailing byte at line end, with no strobe, and start the next line at bf=0.
REQ-026 SHALL drive pre_vs/pre_hs as S1 vsync/href delayed one further register, so both have 2-cycle latency and are aligned with cam_data, each ANDed with frame_valid.
REQ-027 SHALL hold cam_data at its last packed value when pre_wr_en=0.
REQ-028 SHALL keep pix_cnt (12 bits), incremented on each packed pixel and cleared on hs_fall.
REQ-029 SHALL, on hs_fall with frame_valid=1 and pix_cnt≠H_PIX, set err_line; err_line clears on vs_rise.
REQ-030 SHALL treat simultaneous hs_fall and vs_rise as clear winning.
REQ-031 SHALL keep line_cnt (11 bits), incremented on hs_fall and cleared on vs_rise.
REQ-032 SHALL, on vs_rise with frame_valid=1 and line_cnt≠V_LINES, pulse err_frame for 1 cycle; no pulse occurs for the vs_rise that sets frame_valid.
REQ-033 SHALL saturate pix_cnt and line_cnt at all-ones rather than wrap.
REQ-034 SHALL treat href=1 while vsync=1 as normal data, with no special handling.

Reset
REQ-035 SHALL, on sys_rst_n=0, immediately clear all outputs, S1/S2 registers, bf, frame_cnt and all counters to 0.
REQ-036 SHALL, after reset asserted mid-frame, rerun the full FRAME_SKIP sequence with no output until it completes.

Verification
REQ-037 SHALL cover: FRAME_SKIP=2 with 4 frames of 4 lines×8 px -> pre_wr_en fires only in frames 3-4, 32 strobes each, first strobe 2 cycles after the 2nd byte.
REQ-038 SHALL cover: bytes 0xAB,0xCD on a valid line -> cam_data=0xABCD with pre_wr_en=1 for exactly one cycle.
REQ-039 SHALL cover: a valid line with 15 bytes and H_PIX=8 -> 7 strobes, odd byte dropped, err_line=1 until the next vs_rise; the next line starts aligned.
REQ-040 SHALL cover: a frame of 3 lines with V_LINES=4 (after enable) -> err_frame pulses once at the next vs_rise.
REQ-041 SHALL cover: reset pulse mid-frame 3 with FRAME_SKIP=2 -> all outputs 0 immediately; output resumes only after 2 further full frames.
REQ-042 SHALL cover: pre_vs/pre_hs edges lag cam_vsync/cam_href by 2 cycles and stay 0 while frame_valid=0.

Source files
------------

// File: rtl/cam_capture.sv
// DVP camera byte-to-pixel capture: registers the sensor bus, packs RGB565 byte pairs,
// suppresses output for the first FRAME_SKIP frames and flags line/frame size errors.
module cam_capture #(
    parameter int FRAME_SKIP = 10,
    parameter int H_PIX      = 1024,
    parameter int V_LINES    = 768
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_din,
    output logic        pre_wr_en,
    output logic        pre_vs,
    output logic        pre_hs,
    output logic [15:0] cam_data,
    output logic        frame_valid,
    output logic        err_line,
    output logic        err_frame
);

    localparam int FC_W = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
    localparam logic [FC_W-1:0] FC_MAX    = FC_W'(FRAME_SKIP);
    localparam logic [11:0]     H_PIX_C   = 12'(H_PIX);
    localparam logic [10:0]     V_LINES_C = 11'(V_LINES);

    logic            vsync_p1, href_p1;
    logic [7:0]      din_p1;
    logic            vsync_p2, href_p2;
    logic            vs_rise, hs_fall;
    logic [FC_W-1:0] frame_cnt;
    logic            bf;
    logic [7:0]      high_byte;
    logic [11:0]     pix_cnt;
    logic [10:0]     line_cnt;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (&v) ? v : v + 12'd1;
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (&v) ? v : v + 11'd1;
    endfunction

    // S1: input registers; S2: previous S1 sync values for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vsync_p1 <= 1'b0;
            href_p1  <= 1'b0;
            din_p1   <= 8'd0;
            vsync_p2 <= 1'b0;
            href_p2  <= 1'b0;
        end else begin
            vsync_p1 <= cam_vsync;
            href_p1  <= cam_href;
            din_p1   <= cam_din;
            vsync_p2 <= vsync_p1;
            href_p2  <= href_p1;
        end
    end

    always_comb begin
        vs_rise = vsync_p1 & ~vsync_p2;
        hs_fall = ~href_p1 & href_p2;
    end

    // Frame_valid is only reached through vs_rise, so a partial first frame never counts
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt   <= '0;
            frame_valid <= 1'b0;
        end else if (vs_rise) begin
            if (frame_cnt < FC_MAX)
                frame_cnt <= frame_cnt + FC_W'(1);
            else
                frame_valid <= 1'b1;
        end
    end

    // Output stage: byte packing, strobe and sync outputs, all two edges after the pins
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bf        <= 1'b0;
            high_byte <= 8'd0;
            cam_data  <= 16'd0;
            pre_wr_en <= 1'b0;
            pre_vs    <= 1'b0;
            pre_hs    <= 1'b0;
            pix_cnt   <= 12'd0;
        end else begin
            pre_wr_en <= 1'b0;
            pre_vs    <= vsync_p1 & frame_valid;
            pre_hs    <= href_p1 & frame_valid;
            if (href_p1) begin
                bf <= ~bf;
                if (!bf) begin
                    high_byte <= din_p1;
                end else begin
                    cam_data  <= {high_byte, din_p1};
                    pre_wr_en <= frame_valid;
                    pix_cnt   <= sat_inc12(pix_cnt);
                end
            end else begin
                // An odd trailing byte is simply abandoned here
                bf <= 1'b0;
            end
            if (hs_fall)
                pix_cnt <= 12'd0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            line_cnt  <= 11'd0;
            err_line  <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            if (vs_rise) begin
                line_cnt <= 11'd0;
                err_line <= 1'b0;
                if (frame_valid && line_cnt != V_LINES_C)
                    err_frame <= 1'b1;
            end else if (hs_fall) begin
                line_cnt <= sat_inc11(line_cnt);
                if (frame_valid && pix_cnt != H_PIX_C)
                    err_line <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: frame skip, packing/latency via a pixel scoreboard,
// sync alignment, line/frame error flags and mid-frame reset recovery.
module tb_cam_capture;

    localparam int FS = 2;
    localparam int HP = 8;
    localparam int VL = 4;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        cam_vsync, cam_href;
    logic [7:0]  cam_din;
    logic        pre_wr_en, pre_vs, pre_hs, frame_valid, err_line, err_frame;
    logic [15:0] cam_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int errf_cnt = 0;
    int chk_mode = 0;
    logic vs_d1 = 1'b0, vs_d2 = 1'b0, hs_d1 = 1'b0, hs_d2 = 1'b0;
    logic [15:0] last_pix = 16'd0;
    exp_t q[$];

    cam_capture #(.FRAME_SKIP(FS), .H_PIX(HP), .V_LINES(VL)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_din     (cam_din),
        .pre_wr_en   (pre_wr_en),
        .pre_vs      (pre_vs),
        .pre_hs      (pre_hs),
        .cam_data    (cam_data),
        .frame_valid (frame_valid),
        .err_line    (err_line),
        .err_frame   (err_frame)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc   <= cyc + 1;
        vs_d1 <= cam_vsync;
        vs_d2 <= vs_d1;
        hs_d1 <= cam_href;
        hs_d2 <= hs_d1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: scoreboard pop on every strobe, sync-output model check
    always @(negedge sys_clk) begin
        exp_t e;
        if (pre_wr_en === 1'b1) begin
            strobe_cnt++;
            chk("strobe_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pix_data", 32'(cam_data), 32'(e.data));
                chk("pix_latency", 32'(cyc), 32'(e.cyc));
                last_pix = e.data;
            end
        end
        if (err_frame === 1'b1)
            errf_cnt++;
        if (chk_mode == 1)
            chk("sync_zero", 32'({pre_vs, pre_hs}), 32'd0);
        else if (chk_mode == 2)
            chk("sync_follow", 32'({pre_vs, pre_hs}), 32'({vs_d2, hs_d2}));
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},   32'(pre_wr_en),   32'd0);
        chk({tag, "_vs"},      32'(pre_vs),      32'd0);
        chk({tag, "_hs"},      32'(pre_hs),      32'd0);
        chk({tag, "_data"},    32'(cam_data),    32'd0);
        chk({tag, "_fvalid"},  32'(frame_valid), 32'd0);
        chk({tag, "_errline"}, 32'(err_line),    32'd0);
        chk({tag, "_errfrm"},  32'(err_frame),   32'd0);
    endtask

    task automatic line(input int nbytes, input bit push, input bit ab);
        logic [7:0] hi = 8'd0;
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            tick();
            b = 8'($urandom_range(0, 255));
            if (ab && i == 0) b = 8'hAB;
            if (ab && i == 1) b = 8'hCD;
            cam_href = 1'b1;
            cam_din  = b;
            if (i % 2 == 0)
                hi = b;
            else if (push)
                q.push_back('{data: {hi, b}, cyc: cyc + 2});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            cam_href = 1'b0;
            cam_din  = 8'd0;
        end
    endtask

    task automatic vs_pulse(input int mode_pulse, input int mode_body);
        chk_mode = mode_pulse;
        for (int i = 0; i < 4; i++) begin
            tick();
            cam_vsync = (i < 2);
        end
        chk_mode = mode_body;
    endtask

    task automatic do_frame(input int nlines, input int bad, input bit push,
                            input int mode_pulse, input int mode_body, input bit ab);
        strobe_cnt = 0;
        vs_pulse(mode_pulse, mode_body);
        for (int l = 0; l < nlines; l++) begin
            line((l == bad) ? 15 : 16, push, ab && (l == 0));
            if (l == bad)
                chk("err_line_set", 32'(err_line), 32'd1);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_din   = 8'd0;
        #3;
        chk_all_zero("reset");
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (2) tick();

        // Frames 1-2 skipped, 3 enables with 0xAB,0xCD first, 4 steady
        do_frame(4, -1, 1'b0, 1, 1, 1'b0);
        chk("f1_strobes", 32'(strobe_cnt), 32'd0);
        chk("f1_fvalid", 32'(frame_valid), 32'd0);
        do_frame(4, -1, 1'b0, 1, 1, 1'b0);
        chk("f2_strobes", 32'(strobe_cnt), 32'd0);
        chk("f2_fvalid", 32'(frame_valid), 32'd0);
        do_frame(4, -1, 1'b1, 0, 2, 1'b1);
        chk("f3_strobes", 32'(strobe_cnt), 32'd32);
        chk("f3_fvalid", 32'(frame_valid), 32'd1);
        do_frame(4, -1, 1'b1, 2, 2, 1'b0);
        chk("f4_strobes", 32'(strobe_cnt), 32'd32);
        chk("f4_errline", 32'(err_line), 32'd0);

        // Frame 5: second line has 15 bytes; frame 6: only 3 lines
        do_frame(4, 1, 1'b1, 2, 2, 1'b0);
        chk("f5_strobes", 32'(strobe_cnt), 32'd31);
        chk("f5_errline_held", 32'(err_line), 32'd1);
        chk("f5_errframe_cnt", 32'(errf_cnt), 32'd0);
        do_frame(3, -1, 1'b1, 2, 2, 1'b0);
        chk("f6_strobes", 32'(strobe_cnt), 32'd24);
        chk("f6_errline_clr", 32'(err_line), 32'd0);
        chk("f6_errframe_cnt", 32'(errf_cnt), 32'd0);

        // Frame 7: short-frame pulse at its vsync, bad line, then reset mid-frame
        strobe_cnt = 0;
        vs_pulse(2, 2);
        chk("f7_errframe_cnt", 32'(errf_cnt), 32'd1);
        line(15, 1'b1, 1'b0);
        chk("f7_errline", 32'(err_line), 32'd1);
        line(16, 1'b1, 1'b0);
        chk("f7_strobes", 32'(strobe_cnt), 32'd15);
        chk_mode = 0;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) tick();
        sys_rst_n = 1'b1;
        chk_mode = 1;
        strobe_cnt = 0;
        line(16, 1'b0, 1'b0);
        line(16, 1'b0, 1'b0);
        chk("partial_strobes", 32'(strobe_cnt), 32'd0);

        // Two more skipped frames, then output resumes
        do_frame(4, -1, 1'b0, 1, 1, 1'b0);
        chk("a_strobes", 32'(strobe_cnt), 32'd0);
        chk("a_fvalid", 32'(frame_valid), 32'd0);
        do_frame(4, -1, 1'b0, 1, 1, 1'b0);
        chk("b_strobes", 32'(strobe_cnt), 32'd0);
        chk("b_fvalid", 32'(frame_valid), 32'd0);
        do_frame(4, -1, 1'b1, 0, 2, 1'b0);
        chk("c_strobes", 32'(strobe_cnt), 32'd32);
        chk("c_fvalid", 32'(frame_valid), 32'd1);
        chk("c_errframe_cnt", 32'(errf_cnt), 32'd1);

        repeat (3) tick();
        chk("hold_data", 32'(cam_data), 32'(last_pix));
        chk("idle_wr_en", 32'(pre_wr_en), 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
